// File: rtl/core_types_pkg.sv
// Shared front-end predictor types: RAS geometry and the checkpoint that
// travels with each predicted branch so the backend can repair the RAS.
// Optional feature macro: RAS_TOP_REPAIR_EN adds top_target to the checkpoint.
package core_types_pkg;

  localparam int unsigned RAS_ENTRIES      = 8;   // power of 2
  localparam int unsigned RAS_TARGET_WIDTH = 31;  // PC[31:1]
  localparam int unsigned LOG_RAS_ENTRIES  = $clog2(RAS_ENTRIES);
  localparam int unsigned RAS_COUNT_WIDTH  = LOG_RAS_ENTRIES + 1;

  // Snapshot of RAS state captured at prediction time.
  typedef struct packed {
    logic [LOG_RAS_ENTRIES-1:0]  index;
    logic [RAS_COUNT_WIDTH-1:0]  count;
`ifdef RAS_TOP_REPAIR_EN
    logic [RAS_TARGET_WIDTH-1:0] top_target;
`endif
  } ras_checkpoint_t;

endpackage

// File: rtl/ras.sv
// Return Address Stack for the fetch predict stage.
// Circular stack; ras_index points at the most recently pushed entry and
// ras_count tracks occupancy (saturating at RAS_ENTRIES, oldest overwritten).
// Ports:
//   CLK, RST            clock, synchronous active-high reset
//   push_valid/_target  predicted call: push link target
//   pop_valid           predicted return: pop top entry
//   pop_target/pop_hit  zero-latency view of the current top entry
//   ras_index/ras_count current state, checkpointed with each branch
//   update_*            restore a checkpoint on mispredict/flush
// Optional feature macro: RAS_TOP_REPAIR_EN adds update_top_target, which
// also rewrites array[update_ras_index] on restore.
module ras
  import core_types_pkg::*;
(
  input  logic                        CLK,
  input  logic                        RST,
  input  logic                        push_valid,
  input  logic [RAS_TARGET_WIDTH-1:0] push_target,
  input  logic                        pop_valid,
  output logic [RAS_TARGET_WIDTH-1:0] pop_target,
  output logic                        pop_hit,
  output logic [LOG_RAS_ENTRIES-1:0]  ras_index,
  output logic [RAS_COUNT_WIDTH-1:0]  ras_count,
  input  logic                        update_valid,
  input  logic [LOG_RAS_ENTRIES-1:0]  update_ras_index,
`ifdef RAS_TOP_REPAIR_EN
  input  logic [RAS_TARGET_WIDTH-1:0] update_top_target,
`endif
  input  logic [RAS_COUNT_WIDTH-1:0]  update_ras_count
);

  logic [RAS_TARGET_WIDTH-1:0] r_stack [RAS_ENTRIES];
  logic [LOG_RAS_ENTRIES-1:0]  r_index;
  logic [RAS_COUNT_WIDTH-1:0]  r_count;

  ras_checkpoint_t             w_ckpt;
  logic [LOG_RAS_ENTRIES-1:0]  w_index_inc;
  logic [LOG_RAS_ENTRIES-1:0]  w_index_dec;
  logic                        w_empty;
  logic                        w_full;

  // Bundle the restore inputs into the checkpoint view.
  always_comb begin
    w_ckpt            = '0;
    w_ckpt.index      = update_ras_index;
    w_ckpt.count      = update_ras_count;
`ifdef RAS_TOP_REPAIR_EN
    w_ckpt.top_target = update_top_target;
`endif
  end

  // Index arithmetic wraps naturally in LOG_RAS_ENTRIES bits.
  assign w_index_inc = r_index + LOG_RAS_ENTRIES'(1);
  assign w_index_dec = r_index - LOG_RAS_ENTRIES'(1);
  assign w_empty     = (r_count == '0);
  assign w_full      = (r_count == RAS_COUNT_WIDTH'(RAS_ENTRIES));

  // State update; priority RST > update > push/pop.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_index <= '0;
      r_count <= '0;
      for (int i = 0; i < int'(RAS_ENTRIES); i++) begin
        r_stack[i] <= '0;
      end
    end else if (update_valid) begin
      r_index <= w_ckpt.index;
      r_count <= w_ckpt.count;
`ifdef RAS_TOP_REPAIR_EN
      r_stack[w_ckpt.index] <= w_ckpt.top_target;
`endif
    end else if (push_valid && pop_valid) begin
      // Return+link: replace the top in place.
      r_stack[r_index] <= push_target;
      if (w_empty) begin
        r_count <= RAS_COUNT_WIDTH'(1);
      end
    end else if (push_valid) begin
      // When full the wrapped write lands on the oldest entry.
      r_stack[w_index_inc] <= push_target;
      r_index              <= w_index_inc;
      if (!w_full) begin
        r_count <= r_count + RAS_COUNT_WIDTH'(1);
      end
    end else if (pop_valid && !w_empty) begin
      r_index <= w_index_dec;
      r_count <= r_count - RAS_COUNT_WIDTH'(1);
    end
  end

  // Zero-latency read of the pre-edge top; stale on underflow.
  assign pop_target = r_stack[r_index];
  assign pop_hit    = !w_empty;
  assign ras_index  = r_index;
  assign ras_count  = r_count;

endmodule

// File: tb/tb_ras.sv
// Self-checking bench for ras: directed test-plan scenarios followed by a
// random phase, all compared against a plain-integer stack model.
// Optional feature macro: RAS_TOP_REPAIR_EN (bench follows the RTL build).
module tb_ras;
  import core_types_pkg::*;

  logic                        CLK = 1'b0;
  logic                        RST;
  logic                        push_valid;
  logic [RAS_TARGET_WIDTH-1:0] push_target;
  logic                        pop_valid;
  logic [RAS_TARGET_WIDTH-1:0] pop_target;
  logic                        pop_hit;
  logic [LOG_RAS_ENTRIES-1:0]  ras_index;
  logic [RAS_COUNT_WIDTH-1:0]  ras_count;
  logic                        update_valid;
  logic [LOG_RAS_ENTRIES-1:0]  update_ras_index;
  logic [RAS_COUNT_WIDTH-1:0]  update_ras_count;
`ifdef RAS_TOP_REPAIR_EN
  logic [RAS_TARGET_WIDTH-1:0] update_top_target;
`endif

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: array of ints, index and count as plain integers.
  int m_arr [8];
  int m_idx;
  int m_cnt;

  ras dut (
    .CLK              (CLK),
    .RST              (RST),
    .push_valid       (push_valid),
    .push_target      (push_target),
    .pop_valid        (pop_valid),
    .pop_target       (pop_target),
    .pop_hit          (pop_hit),
    .ras_index        (ras_index),
    .ras_count        (ras_count),
    .update_valid     (update_valid),
    .update_ras_index (update_ras_index),
`ifdef RAS_TOP_REPAIR_EN
    .update_top_target(update_top_target),
`endif
    .update_ras_count (update_ras_count)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    check("m_pop_target", 32'(pop_target), 32'(m_arr[m_idx]));
    check("m_pop_hit",    32'(pop_hit),    32'(m_cnt != 0));
    check("m_ras_index",  32'(ras_index),  32'(m_idx));
    check("m_ras_count",  32'(ras_count),  32'(m_cnt));
  endtask

  // Model of one clock edge, from the stack rules.
  task automatic model_edge();
    if (RST) begin
      for (int i = 0; i < 8; i++) m_arr[i] = 0;
      m_idx = 0;
      m_cnt = 0;
    end else if (update_valid) begin
      m_idx = int'(update_ras_index);
      m_cnt = int'(update_ras_count);
`ifdef RAS_TOP_REPAIR_EN
      m_arr[m_idx] = int'(update_top_target);
`endif
    end else if (push_valid && pop_valid) begin
      m_arr[m_idx] = int'(push_target);
      if (m_cnt == 0) m_cnt = 1;
    end else if (push_valid) begin
      m_idx = (m_idx + 1) % 8;
      m_arr[m_idx] = int'(push_target);
      m_cnt = (m_cnt < 8) ? m_cnt + 1 : 8;
    end else if (pop_valid) begin
      if (m_cnt != 0) begin
        m_idx = (m_idx + 7) % 8;
        m_cnt = m_cnt - 1;
      end
    end
  endtask

  // One cycle: check pre-edge outputs at negedge, then advance model at posedge.
  task automatic step();
    @(negedge CLK);
    check_model();
    @(posedge CLK);
    model_edge();
    #1;
  endtask

  task automatic drive(input logic psh, input int tgt, input logic pp);
    push_valid   = psh;
    push_target  = RAS_TARGET_WIDTH'(tgt);
    pop_valid    = pp;
    update_valid = 1'b0;
  endtask

  task automatic do_reset();
    drive(1'b0, 0, 1'b0);
    RST = 1'b1;
    step();
    RST = 1'b0;
  endtask

  task automatic push(input int tgt);
    drive(1'b1, tgt, 1'b0);
    step();
  endtask

  task automatic pop_expect(input string tag, input int exp_tgt);
    drive(1'b0, 0, 1'b1);
    check(tag, 32'(pop_target), 32'(exp_tgt));
    check({tag, "_hit"}, 32'(pop_hit), 32'd1);
    step();
  endtask

  initial begin
    RST = 1'b1;
    drive(1'b0, 0, 1'b0);
    update_ras_index = '0;
    update_ras_count = '0;
`ifdef RAS_TOP_REPAIR_EN
    update_top_target = '0;
`endif
    for (int i = 0; i < 8; i++) m_arr[i] = 0;
    m_idx = 0;
    m_cnt = 0;
    @(posedge CLK);
    #1;
    do_reset();
    check("rst_index",  32'(ras_index),  32'd0);
    check("rst_count",  32'(ras_count),  32'd0);
    check("rst_target", 32'(pop_target), 32'd0);
    check("rst_hit",    32'(pop_hit),    32'd0);

    // Pop on empty
    drive(1'b0, 0, 1'b1);
    check("empty_hit", 32'(pop_hit), 32'd0);
    step();
    drive(1'b0, 0, 1'b0);
    check("empty_index",  32'(ras_index),  32'd0);
    check("empty_count",  32'(ras_count),  32'd0);
    check("empty_target", 32'(pop_target), 32'd0);

    // Three pushes, three pops
    push(32'h100); push(32'h200); push(32'h300);
    check("p3_index", 32'(ras_index), 32'd3);
    check("p3_count", 32'(ras_count), 32'd3);
    pop_expect("pop_300", 32'h300);
    pop_expect("pop_200", 32'h200);
    pop_expect("pop_100", 32'h100);
    check("p3_final_count", 32'(ras_count), 32'd0);

    // Overflow wrap and underflow
    do_reset();
    for (int v = 1; v <= 10; v++) push(v);
    check("wrap_index", 32'(ras_index), 32'd2);
    check("wrap_count", 32'(ras_count), 32'd8);
    for (int k = 0; k < 8; k++) pop_expect("wrap_pop", 10 - k);
    drive(1'b0, 0, 1'b1);
    check("under_hit", 32'(pop_hit), 32'd0);
    step();
    check("under_index", 32'(ras_index), 32'd2);
    check("under_count", 32'(ras_count), 32'd0);

    // Simultaneous push+pop
    do_reset();
    push(32'h40);
    drive(1'b1, 32'h80, 1'b1);
    check("pp_target_pre", 32'(pop_target), 32'h40);
    step();
    check("pp_target", 32'(pop_target), 32'h80);
    check("pp_count",  32'(ras_count),  32'd1);
    check("pp_index",  32'(ras_index),  32'd1);

    // Checkpoint restore after wrong-path activity
    do_reset();
    push(32'h11); push(32'h22);
    check("ck_index", 32'(ras_index), 32'd2);
    check("ck_count", 32'(ras_count), 32'd2);
`ifdef RAS_TOP_REPAIR_EN
    // Wrong path clobbers entry 2 before moving on
    push(32'h33);
    drive(1'b0, 0, 1'b1); step();
    drive(1'b0, 0, 1'b1); step();
    push(32'hBAD);
    push(32'h44); push(32'h55);
    update_top_target = RAS_TARGET_WIDTH'(32'h22);
`else
    push(32'h33); push(32'h44); push(32'h55);
`endif
    drive(1'b1, 32'h66, 1'b0);
    update_valid     = 1'b1;
    update_ras_index = LOG_RAS_ENTRIES'(2);
    update_ras_count = RAS_COUNT_WIDTH'(2);
    step();
    drive(1'b0, 0, 1'b0);
    check("upd_index",  32'(ras_index),  32'd2);
    check("upd_count",  32'(ras_count),  32'd2);
    check("upd_target", 32'(pop_target), 32'h22);

    // Reset overrides a push in flight
    do_reset();
    for (int v = 1; v <= 5; v++) push(v * 16);
    check("rp_count", 32'(ras_count), 32'd5);
    drive(1'b1, 32'h77, 1'b0);
    RST = 1'b1;
    step();
    RST = 1'b0;
    drive(1'b0, 0, 1'b0);
    check("rp_index",  32'(ras_index),  32'd0);
    check("rp_count0", 32'(ras_count),  32'd0);
    check("rp_target", 32'(pop_target), 32'd0);

    // Random traffic against the model
    for (int n = 0; n < 2000; n++) begin
      drive(1'($urandom_range(1)), int'($urandom & 32'h7FFF_FFFF), 1'($urandom_range(1)));
      update_valid     = ($urandom_range(15) == 0);
      update_ras_index = LOG_RAS_ENTRIES'($urandom_range(7));
      update_ras_count = RAS_COUNT_WIDTH'($urandom_range(8));
`ifdef RAS_TOP_REPAIR_EN
      update_top_target = RAS_TARGET_WIDTH'($urandom);
`endif
      RST = ($urandom_range(63) == 0);
      step();
    end
    RST = 1'b0;
    drive(1'b0, 0, 1'b0);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
